// File: rtl/bram_read_arbiter_if.sv
// One requester's view of the shared BRAM read port: a request/grant handshake
// on the way in, and read data with a valid pulse on the way back.
interface bram_read_arbiter_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
);
  logic                  req;
  logic                  lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  gnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (output req, lock, addr, input gnt, rdata, rvalid);
  modport slave  (input req, lock, addr, output gnt, rdata, rvalid);
endinterface

// File: rtl/bram_read_arbiter.sv
// Shares the source-image BRAM read port between the LBP engine (A) and the
// host readback path (B): round-robin with burst lock, gated by a settle timer.
//
// state   | meaning
// S_INIT  | BRAM power-up settle, no grants
// S_FREE  | round-robin between A and B
// S_OWN_A | A holds the port under lock
// S_OWN_B | B holds the port under lock
module bram_read_arbiter #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 19,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CYCLES  = 1024
) (
  input  logic                  clk_p,
  input  logic                  rst,
  bram_read_arbiter_if.slave    a_if,
  bram_read_arbiter_if.slave    b_if,
  output logic                  bram_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i,
  output logic                  init_done_o
);

  localparam int CW = $clog2(INIT_CYCLES) + 1;

  typedef enum logic [1:0] {S_INIT, S_FREE, S_OWN_A, S_OWN_B} state_t;

  state_t                  state_q;
  logic [CW-1:0]           init_cnt_q;
  logic                    init_done_q;
  logic                    last_b_q;
  logic                    bram_en_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic                    en_id_q;
  logic [READ_LATENCY-1:0] sr_vld_q;
  logic [READ_LATENCY-1:0] sr_id_q;
  logic                    a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
  logic                    gnt_a_d, gnt_b_d;
  logic                    ret_a_d, ret_b_d;

  always_comb begin
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    case (state_q)
      S_FREE: begin
        if (a_if.req && b_if.req) begin
          gnt_a_d = last_b_q;
          gnt_b_d = !last_b_q;
        end else begin
          gnt_a_d = a_if.req;
          gnt_b_d = b_if.req;
        end
      end
      S_OWN_A: gnt_a_d = a_if.req;
      S_OWN_B: gnt_b_d = b_if.req;
      default: ;
    endcase
  end

  // Oldest in-flight read is at the top of the shift register when its data is on bram_rdata_i.
  assign ret_a_d = sr_vld_q[READ_LATENCY-1] && !sr_id_q[READ_LATENCY-1];
  assign ret_b_d = sr_vld_q[READ_LATENCY-1] &&  sr_id_q[READ_LATENCY-1];

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      last_b_q    <= 1'b1;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      en_id_q     <= 1'b0;
      sr_vld_q    <= '0;
      sr_id_q     <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + CW'(1);
          if (init_cnt_q == CW'(INIT_CYCLES - 1)) begin
            init_done_q <= 1'b1;
            state_q     <= S_FREE;
          end
        end
        S_FREE: begin
          if (gnt_a_d && a_if.lock)      state_q <= S_OWN_A;
          else if (gnt_b_d && b_if.lock) state_q <= S_OWN_B;
        end
        // Lock low releases the port whether or not this cycle carried a grant.
        S_OWN_A: if (!a_if.lock) state_q <= S_FREE;
        S_OWN_B: if (!b_if.lock) state_q <= S_FREE;
        default: state_q <= S_INIT;
      endcase

      if (gnt_a_d)      last_b_q <= 1'b0;
      else if (gnt_b_d) last_b_q <= 1'b1;

      bram_en_q <= gnt_a_d || gnt_b_d;
      en_id_q   <= gnt_b_d;
      if (gnt_a_d)      bram_addr_q <= a_if.addr;
      else if (gnt_b_d) bram_addr_q <= b_if.addr;

      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_id_q[i]  <= sr_id_q[i-1];
      end
      sr_vld_q[0] <= bram_en_q;
      sr_id_q[0]  <= en_id_q;

      a_rvalid_q <= ret_a_d;
      b_rvalid_q <= ret_b_d;
      if (ret_a_d) a_rdata_q <= bram_rdata_i;
      if (ret_b_d) b_rdata_q <= bram_rdata_i;
    end
  end

  assign a_if.gnt    = gnt_a_d;
  assign b_if.gnt    = gnt_b_d;
  assign a_if.rvalid = a_rvalid_q;
  assign b_if.rvalid = b_rvalid_q;
  assign a_if.rdata  = a_rdata_q;
  assign b_if.rdata  = b_rdata_q;
  assign bram_en_o   = bram_en_q;
  assign bram_addr_o = bram_addr_q;
  assign init_done_o = init_done_q;

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single read port of the source-image BRAM (the SDK-loaded frame) between two requesters.
- Port A is the pixel/LBP processing engine; port B is the host readback/debug path.
- Round-robin arbitration with optional burst lock, so the 8-neighbour LBP fetch can hold the port uninterrupted.
- Gates all traffic until the BRAM power-up settle period has elapsed, then returns read data to the owning requester with a fixed latency.

Parameters:
- DATA_WIDTH, 12, pixel width in bits
- ADDR_WIDTH, 19, BRAM address width
- READ_LATENCY, 1, BRAM cycles from bram_en to bram_rdata valid (1..4)
- INIT_CYCLES, 1024, settle cycles after reset before the first grant

Ports:
- clk_p  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- a_req  input  1  port A read request; held until a_gnt
- a_lock  input  1  port A keeps ownership after this grant
- a_addr  input  ADDR_WIDTH  port A read address, stable while a_req is high
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rdata  output  DATA_WIDTH  port A read data
- a_rvalid  output  1  a_rdata valid, one-cycle pulse
- b_req, b_lock, b_addr, b_gnt, b_rdata, b_rvalid  same as port A, for port B
- bram_en  output  1  BRAM read enable
- bram_addr  output  ADDR_WIDTH  BRAM read address
- bram_rdata  input  DATA_WIDTH  BRAM read data
- init_done  output  1  settle period complete; sticky until reset

Behaviour:
- Reset values:
  - all registered outputs 0; init_done=0
  - FSM in INIT, init counter 0, last-winner = B (so A wins the first tie)
  - in-flight pipeline cleared
- FSM states: INIT, FREE, OWN_A, OWN_B.
- INIT:
  - counter increments each cycle
  - at count INIT_CYCLES-1: init_done<=1, go to FREE
  - no gnt is asserted in INIT
- FREE:
  - only one requester high: grant it
  - both high: grant the one opposite last-winner
  - winner's lock high at grant: next state OWN_winner; otherwise stay FREE
  - last-winner updates on every grant
- OWN_x:
  - only x can be granted; the other requester's req is held off (gnt low)
  - grant to x with lock_x low: next state FREE
  - lock_x deasserted with no req_x: return to FREE without a grant
- Gnt rules:
  - at most one gnt per cycle
  - gnt is high only in a cycle where the matching req is high
  - one grant per cycle sustained throughput
- Datapath timing, for a grant in cycle T:
  - T+1: bram_en=1 and bram_addr = granted address (registered)
  - bram_en=0 in every cycle without a T-1 grant
- Return path:
  - a requester-id/valid shift register of depth READ_LATENCY tracks in-flight reads
  - x_rdata is registered from bram_rdata
  - x_rvalid pulses in cycle T+2+READ_LATENCY, to the originator only
  - returns arrive in grant order
- x_rdata holds its last value when x_rvalid is low.
- Fairness: an unlocked requester waits at most one grant for the other; under a lock it waits until the lock is released.
- Simultaneous events:
  - req and lock rising together in FREE with a competing req: round-robin decides first; lock applies only if that requester wins
- rst mid-operation:
  - in-flight reads are discarded (no rvalid)
  - FSM returns to INIT and the full settle period repeats
- Requester dropping req without gnt is legal: no effect.

Test Plan:
- Init gate: reset, a_req=1 from cycle 0 -> no a_gnt or bram_en until init_done; first a_gnt in the cycle init_done is high after INIT_CYCLES=1024 cycles.
- Single read: after init, a_req with a_addr=401, BRAM preloaded mem[401]=0xABC, READ_LATENCY=1, grant at T -> bram_en/bram_addr=401 at T+1, a_rvalid with a_rdata=0xABC at T+3, b_rvalid stays 0.
- Round robin: a_req and b_req held continuously, addresses 0 and 1 -> grants alternate A,B,A,B; bram_addr alternates 0,1; one rvalid per cycle with correct routing.
- Burst lock: A issues 8 requests (addrs 0,1,2,400,402,800,801,802) with a_lock high on the first 7 while b_req held -> no b_gnt during the burst; b_gnt in the cycle after A's 8th grant; A data returned in issue order.
- Reset mid-flight: assert rst one cycle after a grant -> no rvalid ever for that read; init_done=0; bench checks the full INIT_CYCLES settle repeats before the next grant.
- Latency sweep: READ_LATENCY=3 with a back-to-back A,B,A stream -> each rvalid at grant+5, data and routing correct.
